hdmi_timing_gen: RTL and testbench

Programmable HDMI video timing generator and pixel-stream sequencer for the HDMI controller family. Replaces the fixed-mode raster path with run-time H/V timing, sync polarities, frame-boundary shadowing, and a valid/ready pixel input carrying a start-of-frame marker. It sits between the frame-fetch pixel FIFO and the HDMI_DE/HSYNC/VSYNC/DATA pins, driven by the register block.

---
 rtl/hdmi_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// Purpose: programmable HDMI raster generator; sequences a valid/ready pixel stream onto DE/HSYNC/VSYNC/DATA.
// Latency: all video outputs are registered one cycle after the counter state that produced them.
// Backpressure: PIX_READY is combinational from counter state; mid-frame SOF pixels are held until the next frame.
//
// Ports:
//   ACLK, nRST        clock, synchronous active-low reset
//   EN                generator enable (takes effect at frame boundary)
//   H_*/V_*           region lengths: active, front porch, sync, back porch
//   HSYNC_POL/VSYNC_POL  1 = active-high sync
//   PIX_VALID/PIX_SOF/PIX_DATA/PIX_READY  pixel input stream
//   HDMI_DE/HSYNC/VSYNC/DATA  registered video outputs
//   FRAME_START       pulse alongside first DE of a frame
//   UNDERFLOW         pulse per active pixel not sourced from the stream
module hdmi_timing_gen #(
  parameter int unsigned             C_TIMING_WIDTH = 12,
  parameter int unsigned             C_DATA_WIDTH   = 24,
  parameter logic [C_DATA_WIDTH-1:0] C_BLANK_COLOR  = '0
) (
  input  logic                      ACLK,
  input  logic                      nRST,
  input  logic                      EN,
  input  logic [C_TIMING_WIDTH-1:0] H_ACTIVE,
  input  logic [C_TIMING_WIDTH-1:0] H_FP,
  input  logic [C_TIMING_WIDTH-1:0] H_SYNC,
  input  logic [C_TIMING_WIDTH-1:0] H_BP,
  input  logic [C_TIMING_WIDTH-1:0] V_ACTIVE,
  input  logic [C_TIMING_WIDTH-1:0] V_FP,
  input  logic [C_TIMING_WIDTH-1:0] V_SYNC,
  input  logic [C_TIMING_WIDTH-1:0] V_BP,
  input  logic                      HSYNC_POL,
  input  logic                      VSYNC_POL,
  input  logic                      PIX_VALID,
  input  logic                      PIX_SOF,
  input  logic [C_DATA_WIDTH-1:0]   PIX_DATA,
  output logic                      PIX_READY,
  output logic                      HDMI_DE,
  output logic                      HDMI_HSYNC,
  output logic                      HDMI_VSYNC,
  output logic [C_DATA_WIDTH-1:0]   HDMI_DATA,
  output logic                      FRAME_START,
  output logic                      UNDERFLOW
);

  // Two extra bits so the sum of four maximal fields cannot overflow.
  localparam int unsigned CW = C_TIMING_WIDTH + 2;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  // The run state doubles as the shadowed copy of EN.
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                    state;
  logic [CW-1:0]             h_cnt;
  logic [CW-1:0]             v_cnt;

  logic [C_TIMING_WIDTH-1:0] sh_h_active, sh_h_fp, sh_h_sync, sh_h_bp;
  logic [C_TIMING_WIDTH-1:0] sh_v_active, sh_v_fp, sh_v_sync, sh_v_bp;
  logic                      sh_hsync_pol, sh_vsync_pol;

  function automatic logic [CW-1:0] widen(input logic [C_TIMING_WIDTH-1:0] f);
    return {2'b00, f};
  endfunction

  // Active and sync regions must exist; a programmed 0 behaves as 1.
  function automatic logic [CW-1:0] widen_min1(input logic [C_TIMING_WIDTH-1:0] f);
    return (f == '0) ? ONE : {2'b00, f};
  endfunction

  // Region boundaries, all measured from the start of the line / frame.
  logic [CW-1:0] h_act_end, h_sync_beg, h_sync_end, h_total;
  logic [CW-1:0] v_act_end, v_sync_beg, v_sync_end, v_total;

  assign h_act_end  = widen_min1(sh_h_active);
  assign h_sync_beg = h_act_end + widen(sh_h_fp);
  assign h_sync_end = h_sync_beg + widen_min1(sh_h_sync);
  assign h_total    = h_sync_end + widen(sh_h_bp);

  assign v_act_end  = widen_min1(sh_v_active);
  assign v_sync_beg = v_act_end + widen(sh_v_fp);
  assign v_sync_end = v_sync_beg + widen_min1(sh_v_sync);
  assign v_total    = v_sync_end + widen(sh_v_bp);

  logic running, h_last, v_last, frame_end, shadow_load;
  logic active, first, sof_hold, take;
  logic hsync_on, vsync_on, hpol_eff, vpol_eff;

  assign running     = (state == ST_RUN);
  assign h_last      = (h_cnt == h_total - ONE);
  assign v_last      = (v_cnt == v_total - ONE);
  assign frame_end   = running && h_last && v_last;
  assign shadow_load = !running || frame_end;

  assign active   = running && (h_cnt < h_act_end) && (v_cnt < v_act_end);
  assign first    = active && (h_cnt == '0) && (v_cnt == '0);
  // An SOF arriving anywhere but the first pixel belongs to the next frame.
  assign sof_hold = PIX_VALID && PIX_SOF && !first;

  assign PIX_READY = active && !sof_hold;
  assign take      = PIX_READY && PIX_VALID;

  assign hsync_on = running && (h_cnt >= h_sync_beg) && (h_cnt < h_sync_end);
  assign vsync_on = running && (v_cnt >= v_sync_beg) && (v_cnt < v_sync_end);

  // While idle the shadows track the live inputs every cycle, so use the live
  // polarity directly; this makes the idle level correct from the first cycle
  // after reset even though the shadows were just cleared.
  assign hpol_eff = running ? sh_hsync_pol : HSYNC_POL;
  assign vpol_eff = running ? sh_vsync_pol : VSYNC_POL;

  always_ff @(posedge ACLK) begin
    if (!nRST) begin
      state        <= ST_IDLE;
      h_cnt        <= '0;
      v_cnt        <= '0;
      sh_h_active  <= '0;
      sh_h_fp      <= '0;
      sh_h_sync    <= '0;
      sh_h_bp      <= '0;
      sh_v_active  <= '0;
      sh_v_fp      <= '0;
      sh_v_sync    <= '0;
      sh_v_bp      <= '0;
      sh_hsync_pol <= 1'b0;
      sh_vsync_pol <= 1'b0;
      HDMI_DE      <= 1'b0;
      HDMI_HSYNC   <= 1'b0;
      HDMI_VSYNC   <= 1'b0;
      HDMI_DATA    <= '0;
      FRAME_START  <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      if (shadow_load) begin
        sh_h_active  <= H_ACTIVE;
        sh_h_fp      <= H_FP;
        sh_h_sync    <= H_SYNC;
        sh_h_bp      <= H_BP;
        sh_v_active  <= V_ACTIVE;
        sh_v_fp      <= V_FP;
        sh_v_sync    <= V_SYNC;
        sh_v_bp      <= V_BP;
        sh_hsync_pol <= HSYNC_POL;
        sh_vsync_pol <= VSYNC_POL;
      end

      case (state)
        ST_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (EN) state <= ST_RUN;
        end
        ST_RUN: begin
          if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
              v_cnt <= '0;
              if (!EN) state <= ST_IDLE;
            end else begin
              v_cnt <= v_cnt + ONE;
            end
          end else begin
            h_cnt <= h_cnt + ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      HDMI_DE     <= active;
      HDMI_HSYNC  <= hsync_on ? hpol_eff : ~hpol_eff;
      HDMI_VSYNC  <= vsync_on ? vpol_eff : ~vpol_eff;
      HDMI_DATA   <= take ? PIX_DATA : C_BLANK_COLOR;
      FRAME_START <= first;
      UNDERFLOW   <= active && !take;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
module tb_hdmi_timing_gen;

  localparam int TW = 12;
  localparam int DW = 24;
  localparam logic [DW-1:0] BASE  = 24'hA00000;
  localparam logic [DW-1:0] BLANK = 24'h000000;

  logic          ACLK = 1'b0;
  logic          nRST, EN;
  logic [TW-1:0] H_ACTIVE, H_FP, H_SYNC, H_BP;
  logic [TW-1:0] V_ACTIVE, V_FP, V_SYNC, V_BP;
  logic          HSYNC_POL, VSYNC_POL;
  logic          PIX_VALID, PIX_SOF;
  logic [DW-1:0] PIX_DATA;
  logic          PIX_READY, HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERFLOW;
  logic [DW-1:0] HDMI_DATA;

  always #5 ACLK = ~ACLK;

  hdmi_timing_gen dut (
    .ACLK(ACLK), .nRST(nRST), .EN(EN),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL),
    .PIX_VALID(PIX_VALID), .PIX_SOF(PIX_SOF), .PIX_DATA(PIX_DATA),
    .PIX_READY(PIX_READY),
    .HDMI_DE(HDMI_DE), .HDMI_HSYNC(HDMI_HSYNC), .HDMI_VSYNC(HDMI_VSYNC),
    .HDMI_DATA(HDMI_DATA), .FRAME_START(FRAME_START), .UNDERFLOW(UNDERFLOW)
  );

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Output snapshot taken mid-cycle; p_rdy is PIX_READY just before the edge.
  logic          s_de, s_hs, s_vs, s_fs, s_uf, s_rdy, p_rdy;
  logic [DW-1:0] s_data;
  logic          take;

  // Pixel source: frame number + index within frame, SOF on index 0.
  int src_fnum, src_idx, src_fpix, src_fpix_nxt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL [%s] %s: got 0x%0h want 0x%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int i);
    return BASE + 24'(f * 256 + i);
  endfunction

  task automatic src_drive();
    PIX_DATA = pix(src_fnum, src_idx);
    PIX_SOF  = (src_idx == 0);
  endtask

  task automatic src_skip();
    src_idx  = 0;
    src_fnum++;
    src_fpix = src_fpix_nxt;
    src_drive();
  endtask

  // Called at a negedge; returns at the next negedge with a fresh snapshot.
  task automatic cyc();
    #4;
    p_rdy = PIX_READY;
    take  = PIX_READY && PIX_VALID;
    @(posedge ACLK);
    #1;
    if (take) begin
      src_idx++;
      if (src_idx >= src_fpix) begin
        src_idx  = 0;
        src_fnum++;
        src_fpix = src_fpix_nxt;
      end
      src_drive();
    end
    @(negedge ACLK);
    s_de   = HDMI_DE;
    s_hs   = HDMI_HSYNC;
    s_vs   = HDMI_VSYNC;
    s_fs   = FRAME_START;
    s_uf   = UNDERFLOW;
    s_data = HDMI_DATA;
    s_rdy  = PIX_READY;
  endtask

  // Active test for frame offset k with FP/SYNC/BP = 1/2/1 and V = 3/1/1/1.
  function automatic bit act_at(input int k, input int ha);
    int ht, kk;
    ht = ha + 4;
    kk = k % (ht * 6);
    return ((kk % ht) < ha) && ((kk / ht) < 3);
  endfunction

  task automatic chk_pos(input int k, input int ha, input bit pol);
    int ht, kk, h, v;
    ht = ha + 4;
    kk = k % (ht * 6);
    h  = kk % ht;
    v  = kk / ht;
    chk("de",    32'(s_de), 32'((h < ha) && (v < 3)));
    chk("hsync", 32'(s_hs), 32'(((h >= ha + 1) && (h < ha + 3)) ? pol : !pol));
    chk("vsync", 32'(s_vs), 32'((v == 4) ? pol : !pol));
    chk("fstart", 32'(s_fs), 32'(kk == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    int uf_cnt;
    nRST = 1'b0; EN = 1'b0;
    H_ACTIVE = 4; H_FP = 1; H_SYNC = 2; H_BP = 1;
    V_ACTIVE = 3; V_FP = 1; V_SYNC = 1; V_BP = 1;
    HSYNC_POL = 1'b0; VSYNC_POL = 1'b0;
    PIX_VALID = 1'b0;
    src_fnum = 0; src_idx = 0; src_fpix = 12; src_fpix_nxt = 12;
    src_drive();
    @(negedge ACLK);
    cyc(); cyc();

    phase = "reset";
    chk("de",     32'(s_de),  0);
    chk("hsync",  32'(s_hs),  0);
    chk("vsync",  32'(s_vs),  0);
    chk("data",   32'(s_data), 0);
    chk("fstart", 32'(s_fs),  0);
    chk("uflow",  32'(s_uf),  0);
    chk("ready",  32'(s_rdy), 0);

    phase = "idle";
    nRST = 1'b1;
    cyc();
    chk("hsync", 32'(s_hs), 1);
    chk("vsync", 32'(s_vs), 1);
    chk("de",    32'(s_de), 0);
    chk("ready", 32'(s_rdy), 0);
    HSYNC_POL = 1'b1; VSYNC_POL = 1'b1;
    cyc();
    chk("hsync", 32'(s_hs), 0);
    chk("vsync", 32'(s_vs), 0);

    phase = "start";
    PIX_VALID = 1'b1; EN = 1'b1;
    cyc();
    chk("fstart_t1", 32'(s_fs), 0);
    chk("de_t1",     32'(s_de), 0);
    chk("ready_t1",  32'(s_rdy), 1);
    cyc();

    // Two full frames of 8x6 clocks with continuous aligned input.
    phase = "basic";
    for (int k = 0; k < 96; k++) begin
      int kk, h, v;
      kk = k % 48; h = kk % 8; v = kk / 8;
      chk_pos(k, 4, 1'b1);
      chk("data",  32'(s_data), 32'((h < 4 && v < 3) ? pix(k / 48, v * 4 + h) : BLANK));
      chk("uflow", 32'(s_uf), 0);
      chk("ready", 32'(s_rdy), 32'(act_at(k + 1, 4)));
      cyc();
    end

    // Valid dropped for line 0 pixel 2 of frame 2.
    phase = "drop";
    uf_cnt = 0;
    for (int k = 0; k < 48; k++) begin
      int h, v;
      logic [DW-1:0] exp_d;
      h = k % 8; v = k / 8;
      chk_pos(k, 4, 1'b1);
      if (!(h < 4 && v < 3))  exp_d = BLANK;
      else if (v == 0 && h < 2) exp_d = pix(2, h);
      else if (v == 0 && h == 2) exp_d = BLANK;
      else exp_d = pix(2, v * 4 + h - 1);
      chk("data",  32'(s_data), 32'(exp_d));
      chk("uflow", 32'(s_uf), 32'(k == 2));
      chk("ready", 32'(s_rdy), 32'(act_at(k + 1, 4)));
      if (k == 2) chk("ready_novalid", 32'(p_rdy), 1);
      if (s_uf) uf_cnt++;
      if (k == 1) PIX_VALID = 1'b0;
      if (k == 2) PIX_VALID = 1'b1;
      if (k == 40) src_skip();  // discard the leftover pixel during blanking
      cyc();
    end
    chk("uflow_count", 32'(uf_cnt), 1);

    // SOF appears at line 1 pixel 0 of frame 3.
    phase = "sof_mid";
    uf_cnt = 0;
    for (int k = 0; k < 48; k++) begin
      int h, v;
      bit a;
      h = k % 8; v = k / 8;
      a = (h < 4 && v < 3);
      chk_pos(k, 4, 1'b1);
      chk("data",  32'(s_data), 32'((a && v == 0) ? pix(3, h) : BLANK));
      chk("uflow", 32'(s_uf), 32'(a && v >= 1));
      chk("ready", 32'(s_rdy), 32'(act_at(k + 1, 4) && !(k >= 8 && k < 47)));
      if (k == 8) chk("ready_sof_held", 32'(p_rdy), 0);
      if (s_uf) uf_cnt++;
      if (k == 7) src_skip();
      cyc();
    end
    chk("uflow_count", 32'(uf_cnt), 8);

    // H_ACTIVE 4 -> 6 requested at line 1; applies from the next frame.
    phase = "hchange_old";
    for (int k = 0; k < 48; k++) begin
      int h, v;
      h = k % 8; v = k / 8;
      chk_pos(k, 4, 1'b1);
      chk("data",  32'(s_data), 32'((h < 4 && v < 3) ? pix(4, v * 4 + h) : BLANK));
      chk("uflow", 32'(s_uf), 0);
      chk("ready", 32'(s_rdy), 32'(act_at(k + 1, 4)));
      if (k == 7) begin
        H_ACTIVE = 6;
        src_fpix_nxt = 18;
      end
      cyc();
    end
    phase = "hchange_new";
    for (int k = 0; k < 60; k++) begin
      int h, v;
      h = k % 10; v = k / 10;
      chk_pos(k, 6, 1'b1);
      chk("data",  32'(s_data), 32'((h < 6 && v < 3) ? pix(5, v * 6 + h) : BLANK));
      chk("uflow", 32'(s_uf), 0);
      chk("ready", 32'(s_rdy), 32'(act_at(k + 1, 6)));
      cyc();
    end

    // EN and polarity dropped mid-frame; frame completes with old settings.
    phase = "en_drop";
    for (int k = 0; k < 60; k++) begin
      int h, v;
      h = k % 10; v = k / 10;
      chk_pos(k, 6, 1'b1);
      chk("data",  32'(s_data), 32'((h < 6 && v < 3) ? pix(6, v * 6 + h) : BLANK));
      chk("ready", 32'(s_rdy), 32'((k == 59) ? 1'b0 : act_at(k + 1, 6)));
      if (k == 10) begin
        EN = 1'b0; HSYNC_POL = 1'b0; VSYNC_POL = 1'b0;
      end
      cyc();
    end
    phase = "en_idle";
    for (int i = 0; i < 3; i++) begin
      chk("de",     32'(s_de), 0);
      chk("hsync",  32'(s_hs), 1);
      chk("vsync",  32'(s_vs), 1);
      chk("fstart", 32'(s_fs), 0);
      chk("uflow",  32'(s_uf), 0);
      chk("ready",  32'(s_rdy), 0);
      cyc();
    end
    phase = "en_restart";
    EN = 1'b1;
    cyc();
    chk("fstart_t1", 32'(s_fs), 0);
    chk("hsync_t1",  32'(s_hs), 1);
    cyc();
    phase = "neg_pol";
    for (int k = 0; k < 60; k++) begin
      int h, v;
      h = k % 10; v = k / 10;
      chk_pos(k, 6, 1'b0);
      chk("data",  32'(s_data), 32'((h < 6 && v < 3) ? pix(7, v * 6 + h) : BLANK));
      chk("uflow", 32'(s_uf), 0);
      chk("ready", 32'(s_rdy), 32'(act_at(k + 1, 6)));
      cyc();
    end

    // One-cycle reset in the H sync region of line 0, EN held high.
    phase = "mid_reset";
    for (int k = 0; k < 7; k++) begin
      chk_pos(k, 6, 1'b0);
      chk("data", 32'(s_data), 32'((k < 6) ? pix(8, k) : BLANK));
      if (k == 6) nRST = 1'b0;
      cyc();
    end
    chk("de",     32'(s_de),  0);
    chk("hsync",  32'(s_hs),  0);
    chk("vsync",  32'(s_vs),  0);
    chk("data",   32'(s_data), 0);
    chk("fstart", 32'(s_fs),  0);
    chk("uflow",  32'(s_uf),  0);
    chk("ready",  32'(s_rdy), 0);
    nRST = 1'b1;
    src_skip();
    cyc();
    chk("fstart_t1", 32'(s_fs), 0);
    chk("hsync_t1",  32'(s_hs), 1);
    chk("vsync_t1",  32'(s_vs), 1);
    chk("de_t1",     32'(s_de), 0);
    cyc();
    chk("fstart_t2", 32'(s_fs), 1);
    chk("de_t2",     32'(s_de), 1);
    chk("data_t2",   32'(s_data), 32'(pix(9, 0)));
    chk("hsync_t2",  32'(s_hs), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
